hpdcache_fifo_lvl: RTL
======================

// Module: hpdcache_fifo_lvl
// PURPOSE
//  Register-based FIFO with occupancy tracking, programmable almost-full/almost-empty
//  flags and a synchronous flush. Successor of the plain register FIFO, sized for
//  miss-handler and write-buffer queues that need early back-pressure.
//  Any depth >= 2, power of two or not; optional write-to-read feedthrough.
// PARAMETERS
//  FIFO_DEPTH     4      number of entries; must be >= 2 (elaboration $fatal otherwise)
//  FEEDTHROUGH    1'b0   1: write data visible on rdata_o in the same cycle when empty
//  AFULL_THRESH   DEPTH-1  afull_o asserted when usage >= AFULL_THRESH (1..DEPTH)
//  AEMPTY_THRESH  1      aempty_o asserted when usage <= AEMPTY_THRESH (0..DEPTH-1)
//  fifo_data_t    logic  entry payload type
// PORTS
//  clk_i     in   1           clock, rising edge
//  rst_ni    in   1           asynchronous active-low reset
//  flush_i   in   1           synchronous flush; discards all entries
//  w_i       in   1           write request
//  wok_o     out  1           write accepted when w_i & wok_o
//  wdata_i   in   fifo_data_t write payload
//  r_i       in   1           read request
//  rok_o     out  1           read valid; pop when r_i & rok_o
//  rdata_o   out  fifo_data_t head entry (or wdata_i under feedthrough-when-empty)
//  usage_o   out  UW          entries stored, UW = $clog2(FIFO_DEPTH+1)
//  afull_o   out  1           registered almost-full flag
//  aempty_o  out  1           registered almost-empty flag
// BEHAVIOUR
//  - Reset: pointers 0, usage 0; wok_o=1, rok_o=0 (FEEDTHROUGH: rok_o=w_i), afull_o=0
//    (1 only if AFULL_THRESH==0, disallowed), aempty_o=1. Storage not reset.
//  - Pointers wrap DEPTH-1 -> 0 explicitly (no modulo 2^n). Full/empty from usage_q.
//  - Write latency 1: entry written at wptr is readable on rdata_o the next cycle.
//  - rok_o = (usage_q != 0) | (FEEDTHROUGH & w_i); wok_o = (usage_q != DEPTH) | (FEEDTHROUGH & r_i).
//  - Empty + FEEDTHROUGH + w_i & r_i: bypass, nothing stored, usage unchanged.
//  - Empty + FEEDTHROUGH + w_i & ~r_i: rdata_o=wdata_i, entry stored, usage+1.
//  - Full + FEEDTHROUGH + w_i & r_i: pop head and push new in same cycle, usage stays DEPTH.
//  - Full, FEEDTHROUGH=0: write refused even when r_i=1 (wok_o=0).
//  - Otherwise simultaneous push/pop: usage unchanged, both pointers advance.
//  - usage_d = usage_q + push - pop; never exceeds DEPTH or drops below 0 (asserted).
//  - afull_o/aempty_o are flops computed from usage_d (aligned with usage_o next cycle).
//  - flush_i: during flush cycle wok_o=0, rok_o=0, w_i/r_i ignored; next cycle
//    pointers=0, usage=0, flags at reset values. Flush has priority over everything.
//  - Reset mid-operation: all state returns to reset values asynchronously; contents lost.
// CONFIGURATION
//  `HPDCACHE_FIFO_STATS_EN defined: adds outputs
//    hwm_o  out UW  high-water mark, max usage_q since reset (flush does NOT clear)
//    ovf_o  out 1   sticky, set on any cycle with w_i & ~wok_o & ~flush_i; cleared by reset only
//  Not defined: ports absent, no counters/flops synthesised; all other behaviour identical.
// STRUCTURE
//  - hpdcache_fifo_pkg: function fifo_usage_width(depth) and typedef-free helper
//    fifo_ptr_inc(ptr, depth) shared with other queue blocks.
//  - Sub-module hpdcache_fifo_ptr (wrap-around pointer counter: inc_i, clr_i, ptr_o),
//    instantiated twice (read, write). Storage and flags in this module.
// TESTING
//  - DEPTH=5,FT=0: 5 writes 0xA..0xE -> wok_o=0, usage_o=5, afull_o=1; 5 reads return A..E in order.
//  - DEPTH=5: 12 interleaved push/pop to wrap pointers twice -> data order preserved, usage exact.
//  - DEPTH=4,FT=1 empty: w_i=r_i=1, wdata=0x55 -> rdata_o=0x55 same cycle, usage_o stays 0.
//  - DEPTH=4 full: w_i=r_i=1 -> FT=0: wok_o=0, usage 4->3; FT=1: accepted, usage stays 4.
//  - Usage 3 + flush_i with w_i=r_i=1 -> wok_o=rok_o=0; next cycle usage_o=0, aempty_o=1.
//  - STATS_EN: fill to 4, drain to 1, push while full -> hwm_o=4, ovf_o=1 until rst_ni low.

Source files
------------

// File: rtl/hpdcache_fifo_pkg.sv
// Shared helpers for the HPDcache queue blocks: usage/pointer widths and
// wrap-around pointer increment for arbitrary (non power-of-two) depths.
package hpdcache_fifo_pkg;

  // Bits needed to hold an occupancy count of 0..depth
  function automatic int unsigned fifo_usage_width(int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Bits needed to address depth entries (at least one)
  function automatic int unsigned fifo_ptr_width(int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Next pointer value with explicit wrap from depth-1 back to 0
  function automatic int unsigned fifo_ptr_inc(int unsigned ptr, int unsigned depth);
    return (ptr >= depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/hpdcache_fifo_ptr.sv
// Wrap-around pointer counter for register FIFOs of any depth.
// clr_i has priority over inc_i.
module hpdcache_fifo_ptr
  import hpdcache_fifo_pkg::*;
#(
  parameter int unsigned  DEPTH = 4,
  localparam int unsigned PW    = fifo_ptr_width(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [PW-1:0] ptr_o
);

  logic [PW-1:0] r_ptr_q;
  logic [PW-1:0] w_ptr_d;

  // Next pointer: clear, wrap-increment or hold
  always_comb begin
    w_ptr_d = r_ptr_q;
    if (clr_i) begin
      w_ptr_d = '0;
    end else if (inc_i) begin
      w_ptr_d = PW'(fifo_ptr_inc(32'(r_ptr_q), DEPTH));
    end
  end

  // Pointer register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr_q <= '0;
    end else begin
      r_ptr_q <= w_ptr_d;
    end
  end

  assign ptr_o = r_ptr_q;

endmodule

// File: rtl/hpdcache_fifo_lvl.sv
// Register FIFO with occupancy count, registered almost-full/almost-empty
// flags, synchronous flush and optional write-to-read feedthrough.
// Optional statistics (high-water mark, sticky overflow) under the
// HPDCACHE_FIFO_STATS_EN macro.
module hpdcache_fifo_lvl
  import hpdcache_fifo_pkg::*;
#(
  parameter int unsigned  FIFO_DEPTH    = 4,
  parameter bit           FEEDTHROUGH   = 1'b0,
  parameter int unsigned  AFULL_THRESH  = FIFO_DEPTH - 1,
  parameter int unsigned  AEMPTY_THRESH = 1,
  parameter type          fifo_data_t   = logic,
  localparam int unsigned UW            = fifo_usage_width(FIFO_DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          w_i,
  output logic          wok_o,
  input  fifo_data_t    wdata_i,
  input  logic          r_i,
  output logic          rok_o,
  output fifo_data_t    rdata_o,
  output logic [UW-1:0] usage_o,
  output logic          afull_o,
  output logic          aempty_o
`ifdef HPDCACHE_FIFO_STATS_EN
  ,
  output logic [UW-1:0] hwm_o,
  output logic          ovf_o
`endif
);

  localparam int unsigned PW      = fifo_ptr_width(FIFO_DEPTH);
  localparam logic [UW-1:0] DepthU  = UW'(FIFO_DEPTH);
  localparam logic [UW-1:0] AfullU  = UW'(AFULL_THRESH);
  localparam logic [UW-1:0] AemptyU = UW'(AEMPTY_THRESH);

  if (FIFO_DEPTH < 2) begin : gen_depth_check
    $fatal(1, "hpdcache_fifo_lvl: FIFO_DEPTH must be >= 2");
  end

  fifo_data_t    r_mem [FIFO_DEPTH];
  logic [UW-1:0] r_usage_q;
  logic [UW-1:0] w_usage_d;
  logic          r_afull_q;
  logic          r_aempty_q;
  logic [PW-1:0] w_rptr;
  logic [PW-1:0] w_wptr;
  logic          w_empty;
  logic          w_full;
  logic          w_bypass;
  logic          w_push;
  logic          w_pop;

  // Handshakes, push/pop decode and next occupancy; flush overrides everything
  always_comb begin
    w_empty   = (r_usage_q == '0);
    w_full    = (r_usage_q == DepthU);
    wok_o     = ~flush_i & (~w_full | (FEEDTHROUGH & r_i));
    rok_o     = ~flush_i & (~w_empty | (FEEDTHROUGH & w_i));
    // Empty feedthrough with both requests: data passes straight through
    w_bypass  = FEEDTHROUGH & w_empty & w_i & r_i;
    w_push    = w_i & wok_o & ~w_bypass;
    w_pop     = r_i & rok_o & ~w_bypass;
    rdata_o   = (FEEDTHROUGH && w_empty) ? wdata_i : r_mem[w_rptr];
    w_usage_d = flush_i ? '0 : (r_usage_q + UW'(w_push) - UW'(w_pop));
  end

  hpdcache_fifo_ptr #(
    .DEPTH (FIFO_DEPTH)
  ) u_rptr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (flush_i),
    .inc_i  (w_pop),
    .ptr_o  (w_rptr)
  );

  hpdcache_fifo_ptr #(
    .DEPTH (FIFO_DEPTH)
  ) u_wptr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (flush_i),
    .inc_i  (w_push),
    .ptr_o  (w_wptr)
  );

  // Storage write; contents are intentionally not reset
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[w_wptr] <= wdata_i;
    end
  end

  // Occupancy and flags, flags derived from next usage so they align with usage_o
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_usage_q  <= '0;
      r_afull_q  <= (AFULL_THRESH == 0);
      r_aempty_q <= 1'b1;
    end else begin
      r_usage_q  <= w_usage_d;
      r_afull_q  <= (w_usage_d >= AfullU);
      r_aempty_q <= (w_usage_d <= AemptyU);
    end
  end

  assign usage_o  = r_usage_q;
  assign afull_o  = r_afull_q;
  assign aempty_o = r_aempty_q;

`ifdef HPDCACHE_FIFO_STATS_EN
  logic [UW-1:0] r_hwm_q;
  logic          r_ovf_q;

  // High-water mark survives flush; overflow is sticky until reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_hwm_q <= '0;
      r_ovf_q <= 1'b0;
    end else begin
      if (w_usage_d > r_hwm_q) begin
        r_hwm_q <= w_usage_d;
      end
      if (w_i & ~wok_o & ~flush_i) begin
        r_ovf_q <= 1'b1;
      end
    end
  end

  assign hwm_o = r_hwm_q;
  assign ovf_o = r_ovf_q;
`endif

`ifndef SYNTHESIS
  a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(w_push && !w_pop && w_full));
  a_no_underflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(w_pop && !w_push && w_empty));
`endif

endmodule
